// File: rtl/ysyx_040729_clint_if.sv
// Request/response bus of the core-local interruptor: single outstanding request.
// The CPU side is the master; the CLINT is the slave.
interface ysyx_040729_clint_if #(
  parameter int DATA_WIDTH = 64
);
  logic                    req_valid;
  logic                    req_ready;
  logic                    req_wen;
  logic [63:0]             req_addr;
  logic [DATA_WIDTH-1:0]   req_wdata;
  logic [DATA_WIDTH/8-1:0] req_wmask;
  logic                    resp_valid;
  logic                    resp_ready;
  logic [DATA_WIDTH-1:0]   resp_rdata;
  logic                    resp_err;

  modport master (
    output req_valid, req_wen, req_addr, req_wdata, req_wmask, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_wen, req_addr, req_wdata, req_wmask, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/ysyx_040729_clint.sv
// CLINT: mtime/mtimecmp/msip registers with level timer and software interrupt requests.
// Response one cycle after accept; req_ready drops while a response waits on resp_ready.
module ysyx_040729_clint #(
  parameter int          DATA_WIDTH = 64,
  parameter logic [63:0] BASE       = 64'h0200_0000,
  parameter int          TICK_DIV   = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  ysyx_040729_clint_if.slave       bus,
  output logic                     tirp_o,
  output logic                     sirp_o
);
  localparam int                    CW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0]         DIV_MAX   = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0]         CNT_ONE   = CW'(1);
  localparam logic [DATA_WIDTH-1:0] ONE       = DATA_WIDTH'(1);
  localparam logic [63:0]           OFF_MSIP  = 64'h0000;
  localparam logic [63:0]           OFF_CMP   = 64'h4000;
  localparam logic [63:0]           OFF_MTIME = 64'hBFF8;

  logic [DATA_WIDTH-1:0] mtime_q, mtime_d;
  logic [DATA_WIDTH-1:0] mtimecmp_q, mtimecmp_d;
  logic                  msip_q, msip_d;
  logic [CW-1:0]         div_cnt_q, div_cnt_d;
  logic                  tirp_q, sirp_q;
  logic                  resp_valid_q, resp_valid_d;
  logic                  resp_err_q, resp_err_d;
  logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;

  logic [63:0]           off;
  logic [DATA_WIDTH-1:0] bmask, rd_val;
  logic                  accept, wr, tick, aligned, hit_msip, hit_cmp, hit_mtime, bad;

  always_comb begin
    off       = bus.req_addr - BASE;
    aligned   = (bus.req_addr[2:0] == 3'b000);
    hit_msip  = aligned && (off == OFF_MSIP);
    hit_cmp   = aligned && (off == OFF_CMP);
    hit_mtime = aligned && (off == OFF_MTIME);
    bad       = !(hit_msip || hit_cmp || hit_mtime);
    accept    = bus.req_valid && !resp_valid_q;
    wr        = accept && bus.req_wen && !bad;

    bmask = '0;
    for (int i = 0; i < DATA_WIDTH / 8; i++) begin
      bmask[8*i +: 8] = {8{bus.req_wmask[i]}};
    end

    tick      = (div_cnt_q == DIV_MAX);
    div_cnt_d = tick ? '0 : div_cnt_q + CNT_ONE;

    // A bus write to mtime overrides the same-cycle tick; the prescaler keeps running.
    mtime_d = tick ? mtime_q + ONE : mtime_q;
    if (wr && hit_mtime) begin
      mtime_d = (mtime_q & ~bmask) | (bus.req_wdata & bmask);
    end

    mtimecmp_d = mtimecmp_q;
    if (wr && hit_cmp) begin
      mtimecmp_d = (mtimecmp_q & ~bmask) | (bus.req_wdata & bmask);
    end

    msip_d = msip_q;
    if (wr && hit_msip && bus.req_wmask[0]) begin
      msip_d = bus.req_wdata[0];
    end

    rd_val = '0;
    if (hit_msip)  rd_val = {{(DATA_WIDTH-1){1'b0}}, msip_q};
    if (hit_cmp)   rd_val = mtimecmp_q;
    if (hit_mtime) rd_val = mtime_q;

    resp_valid_d = resp_valid_q;
    resp_err_d   = resp_err_q;
    resp_rdata_d = resp_rdata_q;
    if (accept) begin
      resp_valid_d = 1'b1;
      resp_err_d   = bad;
      resp_rdata_d = (bus.req_wen || bad) ? '0 : rd_val;
    end else if (resp_valid_q && bus.resp_ready) begin
      resp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mtime_q      <= '0;
      mtimecmp_q   <= '1;
      msip_q       <= 1'b0;
      div_cnt_q    <= '0;
      tirp_q       <= 1'b0;
      sirp_q       <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      mtime_q      <= mtime_d;
      mtimecmp_q   <= mtimecmp_d;
      msip_q       <= msip_d;
      div_cnt_q    <= div_cnt_d;
      tirp_q       <= (mtime_q >= mtimecmp_q);
      sirp_q       <= msip_q;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign bus.req_ready  = !resp_valid_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign tirp_o         = tirp_q;
  assign sirp_o         = sirp_q;
endmodule

// File: tb/tb_ysyx_040729_clint.sv
// Bench for the CLINT: two instances (TICK_DIV 1 and 4) against a model that derives
// mtime from the edge count since the last write, plus randomized bus traffic.
module tb_ysyx_040729_clint;
  localparam logic [63:0] BASE = 64'h0200_0000;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  ysyx_040729_clint_if #(.DATA_WIDTH(64)) bus0 ();
  ysyx_040729_clint_if #(.DATA_WIDTH(64)) bus1 ();
  logic tirp [2];
  logic sirp [2];

  ysyx_040729_clint #(.DATA_WIDTH(64), .BASE(BASE), .TICK_DIV(1)) dut0 (
    .clock(clock), .reset(reset), .bus(bus0), .tirp_o(tirp[0]), .sirp_o(sirp[0])
  );
  ysyx_040729_clint #(.DATA_WIDTH(64), .BASE(BASE), .TICK_DIV(4)) dut1 (
    .clock(clock), .reset(reset), .bus(bus1), .tirp_o(tirp[1]), .sirp_o(sirp[1])
  );

  int          t_sel = 0;
  logic        t_valid = 1'b0, t_wen = 1'b0, t_rready = 1'b0;
  logic [63:0] t_addr = '0, t_wdata = '0;
  logic [7:0]  t_wmask = '0;

  assign bus0.req_valid  = t_valid && (t_sel == 0);
  assign bus1.req_valid  = t_valid && (t_sel == 1);
  assign bus0.resp_ready = t_rready && (t_sel == 0);
  assign bus1.resp_ready = t_rready && (t_sel == 1);
  assign bus0.req_wen = t_wen;   assign bus1.req_wen = t_wen;
  assign bus0.req_addr = t_addr; assign bus1.req_addr = t_addr;
  assign bus0.req_wdata = t_wdata; assign bus1.req_wdata = t_wdata;
  assign bus0.req_wmask = t_wmask; assign bus1.req_wmask = t_wmask;

  logic        r_valid, r_ready, r_err;
  logic [63:0] r_rdata;
  assign r_valid = (t_sel == 1) ? bus1.resp_valid : bus0.resp_valid;
  assign r_ready = (t_sel == 1) ? bus1.req_ready  : bus0.req_ready;
  assign r_err   = (t_sel == 1) ? bus1.resp_err   : bus0.resp_err;
  assign r_rdata = (t_sel == 1) ? bus1.resp_rdata : bus0.resp_rdata;

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Model: mtime after edge e = anchor value + number of ticks in (anchor edge, e].
  // A tick falls on edge e (counted from reset) whenever e is a multiple of TICK_DIV.
  int          td [2] = '{1, 4};
  int          edge_cnt = 0;
  logic [63:0] an_val [2], an_pval [2];
  int          an_edge [2], an_pedge [2];
  logic [63:0] cmp_new [2], cmp_old [2];
  int          cmp_edge [2];
  logic        msip_new [2], msip_old [2];
  int          msip_edge [2];

  always @(posedge clock) edge_cnt <= reset ? 0 : edge_cnt + 1;

  function automatic logic [63:0] mt_at(input int s, input int e);
    if (e >= an_edge[s]) return an_val[s] + 64'(e / td[s] - an_edge[s] / td[s]);
    return an_pval[s] + 64'(e / td[s] - an_pedge[s] / td[s]);
  endfunction

  function automatic logic [63:0] cmp_at(input int s, input int e);
    return (e >= cmp_edge[s]) ? cmp_new[s] : cmp_old[s];
  endfunction

  function automatic logic msip_at(input int s, input int e);
    return (e >= msip_edge[s]) ? msip_new[s] : msip_old[s];
  endfunction

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] wd,
                                        input logic [7:0] wm);
    logic [63:0] m;
    for (int i = 0; i < 8; i++) m[8*i +: 8] = {8{wm[i]}};
    return (old & ~m) | (wd & m);
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      an_val[s] = '0; an_pval[s] = '0; an_edge[s] = 0; an_pedge[s] = 0;
      cmp_new[s] = ONES; cmp_old[s] = ONES; cmp_edge[s] = 0;
      msip_new[s] = 1'b0; msip_old[s] = 1'b0; msip_edge[s] = 0;
    end
  endtask

  // Interrupt outputs lag the registers by one edge.
  always @(negedge clock) begin
    if (!reset && edge_cnt >= 1) begin
      for (int s = 0; s < 2; s++) begin
        check_val(s == 0 ? "tirp0" : "tirp1", tirp[s],
                  64'(mt_at(s, edge_cnt - 1) >= cmp_at(s, edge_cnt - 1)));
        check_val(s == 0 ? "sirp0" : "sirp1", sirp[s], 64'(msip_at(s, edge_cnt - 1)));
      end
    end
  end

  // Called at a negedge with the port idle; returns at a negedge with the port idle.
  task automatic txn(input int s, input logic wen, input logic [63:0] addr,
                     input logic [63:0] wd, input logic [7:0] wm, input int hold);
    int          e;
    logic [63:0] off, exp_rd, old;
    logic        exp_err;
    t_sel = s;
    check_val("req_ready_idle", r_ready, 1);
    e       = edge_cnt + 1;
    off     = addr - BASE;
    exp_err = !((addr[2:0] == 3'b000) && (off == 64'h0 || off == 64'h4000 || off == 64'hBFF8));
    exp_rd  = '0;
    if (!exp_err) begin
      if (off == 64'h0) begin
        if (!wen) exp_rd = {63'b0, msip_at(s, e - 1)};
        else begin
          msip_old[s]  = msip_at(s, e - 1);
          msip_new[s]  = wm[0] ? wd[0] : msip_old[s];
          msip_edge[s] = e;
        end
      end else if (off == 64'h4000) begin
        if (!wen) exp_rd = cmp_at(s, e - 1);
        else begin
          cmp_old[s]  = cmp_at(s, e - 1);
          cmp_new[s]  = merge(cmp_old[s], wd, wm);
          cmp_edge[s] = e;
        end
      end else begin
        old = mt_at(s, e - 1);
        if (!wen) exp_rd = old;
        else begin
          an_pval[s] = an_val[s]; an_pedge[s] = an_edge[s];
          an_val[s]  = merge(old, wd, wm);
          an_edge[s] = e;
        end
      end
    end
    t_wen = wen; t_addr = addr; t_wdata = wd; t_wmask = wm; t_valid = 1'b1; t_rready = 1'b0;
    @(negedge clock);
    t_valid = 1'b0;
    if (hold > 0) begin
      // A competing msip flip while the response waits; it must not be accepted.
      t_valid = 1'b1; t_wen = 1'b1; t_addr = BASE; t_wmask = 8'hFF;
      t_wdata = {63'b0, ~msip_at(s, e)};
    end
    t_rready = (hold == 0);
    check_val("resp_valid", r_valid, 1);
    check_val("resp_rdata", r_rdata, exp_rd);
    check_val("resp_err", r_err, 64'(exp_err));
    for (int i = 1; i <= hold; i++) begin
      @(negedge clock);
      check_val("hold_valid", r_valid, 1);
      check_val("hold_rdata", r_rdata, exp_rd);
      check_val("hold_err", r_err, 64'(exp_err));
      check_val("hold_ready", r_ready, 0);
      if (i == hold) begin
        t_rready = 1'b1;
        t_valid  = 1'b0;
      end
    end
    @(negedge clock);
    check_val("resp_drop", r_valid, 0);
    t_rready = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  function automatic logic [63:0] rand64();
    return {32'($urandom), 32'($urandom)};
  endfunction

  function automatic logic [63:0] rand_addr();
    logic [63:0] bad_offs [4] = '{64'h8, 64'h4008, 64'hBFF0, 64'h1_0000};
    logic [63:0] good_offs [3] = '{64'h0, 64'h4000, 64'hBFF8};
    case ($urandom_range(0, 9))
      0:       return BASE + bad_offs[$urandom_range(0, 3)];
      1:       return BASE + good_offs[$urandom_range(0, 2)] + 64'($urandom_range(1, 7));
      2, 3:    return BASE;
      4, 5, 6: return BASE + 64'h4000;
      default: return BASE + 64'hBFF8;
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] a, wd;
    logic [7:0]  wm;
    int          s;
    reset = 1'b1;
    model_reset();
    idle(3);
    reset = 1'b0;
    @(negedge clock);
    for (int k = 0; k < 2; k++) begin
      t_sel = k;
      #1;
      check_val("rst_resp_valid", r_valid, 0);
      check_val("rst_resp_rdata", r_rdata, 0);
      check_val("rst_resp_err", r_err, 0);
      check_val("rst_req_ready", r_ready, 1);
    end
    t_sel = 0;

    while (edge_cnt < 5) @(negedge clock);
    txn(0, 1'b0, BASE + 64'hBFF8, '0, 8'h00, 0);
    txn(0, 1'b0, BASE + 64'h4000, '0, 8'h00, 0);
    txn(0, 1'b1, BASE + 64'h4000, 64'd20, 8'hFF, 0);
    idle(15);
    txn(0, 1'b1, BASE + 64'h4000, ONES, 8'hFF, 0);
    idle(3);

    txn(0, 1'b1, BASE + 64'h4000, 64'd10, 8'hFF, 0);
    idle(2);
    txn(0, 1'b1, BASE + 64'hBFF8, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, 0);
    txn(0, 1'b0, BASE + 64'hBFF8, '0, 8'h00, 0);
    txn(0, 1'b0, BASE + 64'hBFF8, '0, 8'h00, 0);
    idle(3);

    txn(0, 1'b1, BASE + 64'h4000, ONES, 8'hFF, 0);
    txn(0, 1'b1, BASE + 64'h4000, 64'hAB, 8'h01, 0);
    txn(0, 1'b0, BASE + 64'h4000, '0, 8'h00, 0);
    txn(0, 1'b1, BASE + 64'h4000, 64'h0, 8'h00, 0);
    txn(0, 1'b1, BASE + 64'h0008, ONES, 8'hFF, 0);
    txn(0, 1'b0, BASE + 64'h0008, '0, 8'h00, 0);
    txn(0, 1'b0, BASE + 64'h4000, '0, 8'h00, 0);
    txn(0, 1'b1, BASE, 64'h1, 8'hFF, 0);
    txn(0, 1'b0, BASE + 64'hBFF8, '0, 8'h00, 4);
    txn(0, 1'b0, BASE, '0, 8'h00, 2);

    // Write mtime exactly on a tick edge of the divided instance, then watch the next tick.
    while ((edge_cnt + 1) % 4 != 0) @(negedge clock);
    txn(1, 1'b1, BASE + 64'hBFF8, 64'd100, 8'hFF, 0);
    txn(1, 1'b0, BASE + 64'hBFF8, '0, 8'h00, 0);
    idle(1);
    txn(1, 1'b0, BASE + 64'hBFF8, '0, 8'h00, 0);
    txn(1, 1'b0, BASE + 64'hBFF8, '0, 8'h00, 1);

    // Reset while a response is pending: it must vanish.
    t_sel = 0;
    t_wen = 1'b0; t_addr = BASE + 64'hBFF8; t_wmask = 8'h00; t_valid = 1'b1;
    @(negedge clock);
    t_valid = 1'b0;
    check_val("pre_rst_valid", r_valid, 1);
    reset = 1'b1;
    @(negedge clock);
    model_reset();
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check_val("mid_rst_valid", r_valid, 0);
    check_val("mid_rst_rdata", r_rdata, 0);
    check_val("mid_rst_ready", r_ready, 1);
    txn(0, 1'b0, BASE + 64'h4000, '0, 8'h00, 0);
    txn(0, 1'b0, BASE, '0, 8'h00, 0);

    for (int i = 0; i < 150; i++) begin
      s  = ($urandom_range(0, 3) == 3) ? 1 : 0;
      a  = rand_addr();
      wm = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
      wd = rand64();
      if (a == BASE + 64'h4000) begin
        case ($urandom_range(0, 3))
          0:       wd = ONES;
          1:       wd = 64'($urandom_range(0, 40));
          default: wd = mt_at(s, edge_cnt) + 64'($urandom_range(0, 12));
        endcase
      end else if (a == BASE + 64'hBFF8) begin
        case ($urandom_range(0, 2))
          0:       wd = 64'($urandom_range(0, 40));
          1:       wd = ONES - 64'($urandom_range(0, 6));
          default: wd = rand64();
        endcase
      end
      txn(s, 1'($urandom_range(0, 1)), a, wd, wm,
          ($urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : 0);
      idle($urandom_range(0, 3));
    end

    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
